// File: rtl/note_keyboard_pkg.sv
// Shared definitions for the keyboard-to-pitch front end: the middle-octave
// semitone table, key-to-semitone maps, sharp masks and the voice state enum.
package note_pkg;

  localparam int unsigned PITCH_W = 11;
  localparam logic [PITCH_W-1:0] SILENCE = 11'd1;

  // Keys whose pitch moves when sharp is selected (bit = key index).
  localparam logic [7:0] HEPT_SHARP_MASK  = 8'b0011_1011; // do re fa so la
  localparam logic [7:0] PENTA_SHARP_MASK = 8'b0001_0100; // mi la

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    RELEASE = 2'd2
  } note_state_e;

  // Middle octave, C5 upward, in Hz.
  function automatic logic [PITCH_W-1:0] mid_semitone_hz(input logic [3:0] semi);
    case (semi)
      4'd0:    return 11'd523;
      4'd1:    return 11'd554;
      4'd2:    return 11'd587;
      4'd3:    return 11'd622;
      4'd4:    return 11'd659;
      4'd5:    return 11'd698;
      4'd6:    return 11'd740;
      4'd7:    return 11'd784;
      4'd8:    return 11'd831;
      4'd9:    return 11'd880;
      4'd10:   return 11'd932;
      4'd11:   return 11'd988;
      default: return SILENCE;
    endcase
  endfunction

  // do re mi fa so la xi
  function automatic logic [3:0] hept_semitone(input logic [2:0] key);
    case (key)
      3'd0:    return 4'd0;
      3'd1:    return 4'd2;
      3'd2:    return 4'd4;
      3'd3:    return 4'd5;
      3'd4:    return 4'd7;
      3'd5:    return 4'd9;
      default: return 4'd11;
    endcase
  endfunction

  // do re mi so la
  function automatic logic [3:0] penta_semitone(input logic [2:0] key);
    case (key)
      3'd0:    return 4'd0;
      3'd1:    return 4'd2;
      3'd2:    return 4'd4;
      3'd3:    return 4'd7;
      default: return 4'd9;
    endcase
  endfunction

  // Heptatonic sharp raises by one semitone; pentatonic sharp remaps
  // mi->fa and la->xi so the legacy five-key layout can reach them.
  function automatic logic [3:0] key_semitone(input logic       penta,
                                              input logic [2:0] key,
                                              input logic       sharp);
    logic [3:0] semi;
    if (penta) begin
      semi = penta_semitone(key);
      if (sharp && PENTA_SHARP_MASK[key]) semi = (semi == 4'd4) ? 4'd5 : 4'd11;
    end else begin
      semi = hept_semitone(key);
      if (sharp && HEPT_SHARP_MASK[key]) semi = semi + 4'd1;
    end
    return semi;
  endfunction

  // oct = sw[2:1]: 10 low, 01 high, otherwise middle.
  function automatic logic [PITCH_W-1:0] octave_scale(input logic [PITCH_W-1:0] mid,
                                                      input logic [1:0]         oct);
    case (oct)
      2'b10:   return (mid + 11'd1) >> 1;
      2'b01:   return mid << 1;
      default: return mid;
    endcase
  endfunction

endpackage

// File: rtl/note_keyboard_debounce.sv
// Single-bit key debouncer: one synchroniser flop, then a counter that must
// see DEB_CNT consecutive disagreeing samples before the output toggles.
module key_debounce #(
  parameter int DEB_CNT = 4
) (
  input  logic CP,
  input  logic rst,
  input  logic btn,
  output logic deb
);

  localparam int CNT_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);

  logic             sync_q, sync_d;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count disagreeing samples; toggle and clear on the last one.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    sync_d = btn;
    deb_d  = deb_q;
    cnt_d  = '0;
    if (sync_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchroniser, counter and debounced value.
  always_ff @(posedge CP) begin
    // NOTE: state updates use non-blocking assignments so all flops sample together.
    if (rst) begin
      sync_q <= 1'b0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign deb = deb_q;

endmodule

// File: rtl/note_keyboard.sv
// Keyboard front end: per-key debounce, last-pressed-wins arbitration,
// play/sustain state machine and a registered pitch output (1 = silence).
module note_keyboard
  import note_pkg::*;
#(
  parameter int N_KEYS         = 7,
  parameter int PENTA          = 0,
  parameter int DEB_CNT        = 4,
  parameter int SUSTAIN_CYCLES = 8,
  parameter int FREQ_W         = 11,
  localparam int IDX_W         = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
  input  logic              CP,
  input  logic              rst,
  input  logic [N_KEYS-1:0] Button,
  input  logic [2:0]        sw,
  output logic [FREQ_W-1:0] frequency,
  output logic              note_valid,
  output logic [IDX_W-1:0]  note_idx,
  output logic              sustaining
);

  localparam int TMR_W = (SUSTAIN_CYCLES > 0) ? $clog2(SUSTAIN_CYCLES + 1) : 1;

  if (FREQ_W < 11) begin : g_bad_freq_w
    $error("note_keyboard: FREQ_W must be at least 11 to hold 1976 Hz");
  end
  if (N_KEYS < 1 || N_KEYS > 7) begin : g_bad_n_keys
    $error("note_keyboard: N_KEYS must be in 1..7");
  end
  if (PENTA != 0 && N_KEYS != 5) begin : g_bad_penta
    $error("note_keyboard: pentatonic mapping needs exactly 5 keys");
  end
  if (DEB_CNT < 1) begin : g_bad_deb
    $error("note_keyboard: DEB_CNT must be at least 1");
  end

  logic [N_KEYS-1:0] deb;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
      .CP  (CP),
      .rst (rst),
      .btn (Button[g]),
      .deb (deb[g])
    );
  end

  logic [N_KEYS-1:0] deb_prev_q, deb_prev_d;
  logic [IDX_W-1:0]  active_q, active_d;
  note_state_e       state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [FREQ_W-1:0] frequency_q, frequency_d;
  logic              note_valid_q, note_valid_d;
  logic [IDX_W-1:0]  note_idx_q, note_idx_d;
  logic              sustaining_q, sustaining_d;

  logic [N_KEYS-1:0] rise;
  logic [IDX_W-1:0]  rise_idx, held_idx;
  logic              active_held;
  logic [PITCH_W-1:0] pitch;

  // Arbitration: a fresh press (lowest index on ties) takes over; if the
  // active key lets go while others are down, fall back to the lowest held.
  always_comb begin
    deb_prev_d  = deb;
    rise        = deb & ~deb_prev_q;
    rise_idx    = '0;
    held_idx    = '0;
    active_held = 1'b0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (rise[i]) rise_idx = IDX_W'(i);
      if (deb[i])  held_idx = IDX_W'(i);
      if (IDX_W'(i) == active_q) active_held = deb[i];
    end
    active_d = active_q;
    if (|rise) begin
      active_d = rise_idx;
    end else if (|deb && !active_held) begin
      active_d = held_idx;
    end
  end

  // Voice state machine: press starts PLAY, full release starts the sustain timer.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (|rise) state_d = PLAY;
      end
      PLAY: begin
        if (~|deb) begin
          if (SUSTAIN_CYCLES > 0) begin
            state_d = RELEASE;
            timer_d = TMR_W'(SUSTAIN_CYCLES);
          end else begin
            state_d = IDLE;
          end
        end
      end
      RELEASE: begin
        if (|rise) begin
          state_d = PLAY;
          timer_d = '0;
        end else if (timer_q <= TMR_W'(1)) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Output pitch from the next active key and the live octave/sharp switches.
  always_comb begin
    pitch = octave_scale(mid_semitone_hz(key_semitone(PENTA != 0, 3'(active_d), sw[0])),
                         sw[2:1]);
    frequency_d  = FREQ_W'(SILENCE);
    note_valid_d = 1'b0;
    note_idx_d   = '0;
    sustaining_d = 1'b0;
    if (state_d != IDLE) begin
      frequency_d  = FREQ_W'(pitch);
      note_valid_d = 1'b1;
      note_idx_d   = active_d;
      sustaining_d = (state_d == RELEASE);
    end
  end

  // State, arbitration and output registers; reset wins over everything.
  always_ff @(posedge CP) begin
    if (rst) begin
      deb_prev_q   <= '0;
      active_q     <= '0;
      state_q      <= IDLE;
      timer_q      <= '0;
      frequency_q  <= FREQ_W'(SILENCE);
      note_valid_q <= 1'b0;
      note_idx_q   <= '0;
      sustaining_q <= 1'b0;
    end else begin
      deb_prev_q   <= deb_prev_d;
      active_q     <= active_d;
      state_q      <= state_d;
      timer_q      <= timer_d;
      frequency_q  <= frequency_d;
      note_valid_q <= note_valid_d;
      note_idx_q   <= note_idx_d;
      sustaining_q <= sustaining_d;
    end
  end

  assign frequency  = frequency_q;
  assign note_valid = note_valid_q;
  assign note_idx   = note_idx_q;
  assign sustaining = sustaining_q;

endmodule

// File: tb/tb_note_keyboard.sv
// Bench for note_keyboard: a heptatonic and a pentatonic instance share the
// stimulus; a reference model pushes expected outputs per edge into a queue
// and a monitor pops and compares them on the falling edge.
module tb_note_keyboard;

  localparam int DEB = 4;
  localparam int SUS = 8;

  logic        CP;
  logic        rst;
  logic [6:0]  btn;
  logic [2:0]  sw;
  logic [10:0] freq7, freq5;
  logic        valid7, valid5, sus7, sus5;
  logic [2:0]  idx7, idx5;

  note_keyboard #(.N_KEYS(7), .PENTA(0), .DEB_CNT(DEB), .SUSTAIN_CYCLES(SUS), .FREQ_W(11)) dut_hept (
    .CP(CP), .rst(rst), .Button(btn), .sw(sw),
    .frequency(freq7), .note_valid(valid7), .note_idx(idx7), .sustaining(sus7)
  );

  note_keyboard #(.N_KEYS(5), .PENTA(1), .DEB_CNT(DEB), .SUSTAIN_CYCLES(SUS), .FREQ_W(11)) dut_penta (
    .CP(CP), .rst(rst), .Button(btn[4:0]), .sw(sw),
    .frequency(freq5), .note_valid(valid5), .note_idx(idx5), .sustaining(sus5)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  typedef struct {
    int freq;
    bit valid;
    int idx;
    bit sus;
  } exp_t;

  typedef struct {
    exp_t e [2];
  } exp_pair_t;

  exp_pair_t sb_q [$];
  int n_vec = 0;
  int n_err = 0;

  // Reference tables straight from the musical description.
  int mid_hz    [12] = '{523, 554, 587, 622, 659, 698, 740, 784, 831, 880, 932, 988};
  int hept_map  [7]  = '{0, 2, 4, 5, 7, 9, 11};
  int penta_map [5]  = '{0, 2, 4, 7, 9};

  function automatic int ref_pitch(int m, int key, logic [2:0] s);
    int semi;
    int hz;
    if (m == 0) begin
      semi = hept_map[key];
      if (s[0] && semi != 4 && semi != 11) semi = semi + 1;
    end else begin
      semi = penta_map[key];
      if (s[0]) begin
        if (semi == 4) semi = 5;
        else if (semi == 9) semi = 11;
      end
    end
    hz = mid_hz[semi];
    if (s[2:1] == 2'b10) hz = (hz + 1) / 2;
    else if (s[2:1] == 2'b01) hz = hz * 2;
    return hz;
  endfunction

  // Model state per instance (0 = heptatonic, 1 = pentatonic).
  bit     d_cur  [2][7];
  bit     d_prev [2][7];
  bit     win    [2][7][DEB];   // last DEB synchronised samples per key
  int     active [2];
  int     mode   [2];           // 0 silent, 1 playing, 2 sustaining
  longint rel_edge [2];
  longint edge_no = 0;

  // One clock edge of the reference: a key's debounced level flips once the
  // last DEB samples all disagree with it; the voice reacts one edge later.
  function automatic exp_t model_step(int m);
    exp_t e;
    int   nk;
    int   first_new;
    int   first_held;
    bit   all_diff;
    nk = (m == 0) ? 7 : 5;
    if (rst) begin
      for (int k = 0; k < 7; k++) begin
        d_cur[m][k]  = 1'b0;
        d_prev[m][k] = 1'b0;
        for (int j = 0; j < DEB; j++) win[m][k][j] = 1'b0;
      end
      active[m] = 0;
      mode[m]   = 0;
    end else begin
      first_new  = -1;
      first_held = -1;
      for (int k = 0; k < nk; k++) begin
        if (d_cur[m][k] && !d_prev[m][k] && first_new < 0) first_new = k;
        if (d_cur[m][k] && first_held < 0) first_held = k;
      end
      if (first_new >= 0) active[m] = first_new;
      else if (first_held >= 0 && !d_cur[m][active[m]]) active[m] = first_held;
      case (mode[m])
        0: if (first_new >= 0) mode[m] = 1;
        1: if (first_held < 0) begin
             mode[m]     = 2;
             rel_edge[m] = edge_no;
           end
        default: begin
          if (first_new >= 0) mode[m] = 1;
          else if (edge_no - rel_edge[m] >= SUS) mode[m] = 0;
        end
      endcase
      for (int k = 0; k < nk; k++) begin
        all_diff = 1'b1;
        for (int j = 0; j < DEB; j++) if (win[m][k][j] == d_cur[m][k]) all_diff = 1'b0;
        d_prev[m][k] = d_cur[m][k];
        if (all_diff) d_cur[m][k] = !d_cur[m][k];
        for (int j = DEB - 1; j > 0; j--) win[m][k][j] = win[m][k][j-1];
        win[m][k][0] = btn[k];
      end
    end
    if (mode[m] == 0) begin
      e.freq = 1; e.valid = 1'b0; e.idx = 0; e.sus = 1'b0;
    end else begin
      e.freq  = ref_pitch(m, active[m], sw);
      e.valid = 1'b1;
      e.idx   = active[m];
      e.sus   = (mode[m] == 2);
    end
    return e;
  endfunction

  // Stimulus side of the scoreboard: predict every edge.
  always @(posedge CP) begin
    exp_pair_t ep;
    edge_no++;
    for (int m = 0; m < 2; m++) ep.e[m] = model_step(m);
    sb_q.push_back(ep);
  end

  task automatic compare_out(string tag, exp_t e, logic [10:0] f, logic v, logic [2:0] i, logic s);
    n_vec++;
    if (f !== 11'(e.freq) || v !== e.valid || i !== 3'(e.idx) || s !== e.sus) begin
      n_err++;
      $display("FAIL %s @%0t: got freq=%0d valid=%b idx=%0d sus=%b, want freq=%0d valid=%b idx=%0d sus=%b",
               tag, $time, f, v, i, s, e.freq, e.valid, e.idx, e.sus);
    end
  endtask

  // Monitor: outputs are presented every cycle, checked mid-cycle.
  always @(negedge CP) begin
    exp_pair_t ep;
    if (sb_q.size() > 0) begin
      ep = sb_q.pop_front();
      compare_out("hept", ep.e[0], freq7, valid7, idx7, sus7);
      compare_out("penta", ep.e[1], freq5, valid5, idx5, sus5);
    end
  end

  task automatic check(string name, logic [31:0] act, int req);
    n_vec++;
    if (act !== 32'(req)) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, req);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge CP);
  endtask

  initial begin
    int hold;
    int cycles;
    rst = 1'b1;
    btn = 7'h7F;
    sw  = 3'b000;

    // Reset with keys down.
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("rst_freq", freq7, 1);
      check("rst_valid", valid7, 0);
      check("rst_idx", idx7, 0);
    end
    rst = 1'b0;
    cyc(1);
    check("post_rst_freq", freq7, 1);
    check("post_rst_valid", valid7, 0);
    check("post_rst_idx", idx7, 0);
    btn = '0;
    cyc(12);

    // Clean press of do, then octave changes.
    btn = 7'h01;
    cyc(5);
    check("press_edge4", freq7, 1);
    cyc(1);
    check("press_edge5", freq7, 523);
    sw = 3'b100;
    cyc(1);
    check("low_do", freq7, 262);
    sw = 3'b010;
    cyc(1);
    check("high_do", freq7, 1046);
    sw  = 3'b000;
    btn = '0;
    cyc(20);

    // Glitch shorter than the debounce window.
    btn = 7'h02;
    cyc(3);
    btn = '0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      check("glitch_valid", valid7, 0);
    end
    check("glitch_freq", freq7, 1);
    cyc(10);

    // Last-pressed-wins and fallback.
    btn = 7'h01;
    cyc(8);
    btn = 7'h11;
    cyc(8);
    check("so_freq", freq7, 784);
    check("so_idx", idx7, 4);
    btn = 7'h01;
    cyc(8);
    check("back_do_freq", freq7, 523);
    check("back_do_idx", idx7, 0);
    btn = 7'h25;
    cyc(8);
    check("tie_freq", freq7, 659);
    check("tie_idx", idx7, 2);
    btn = '0;
    cyc(20);

    // Sharp handling.
    sw  = 3'b001;
    btn = 7'h02;
    cyc(8);
    check("re_sharp", freq7, 622);
    btn = '0;
    cyc(20);
    btn = 7'h04;
    cyc(8);
    check("mi_sharp", freq7, 659);
    sw = 3'b011;
    cyc(2);
    check("penta_mi_sharp_hi", freq5, 1396);
    btn = '0;
    cyc(20);
    sw  = 3'b101;
    btn = 7'h08;
    cyc(8);
    check("penta_so_sharp_lo", freq5, 392);
    btn = '0;
    cyc(20);
    sw = 3'b000;

    // Sustain length.
    btn = 7'h01;
    cyc(8);
    btn = '0;
    cyc(6);
    check("sus_start", sus7, 1);
    check("sus_start_freq", freq7, 523);
    cyc(7);
    check("sus_last_freq", freq7, 523);
    check("sus_last", sus7, 1);
    cyc(1);
    check("sus_over_freq", freq7, 1);
    check("sus_over", sus7, 0);
    cyc(10);

    // Re-press during sustain.
    btn = 7'h01;
    cyc(8);
    btn = '0;
    cyc(3);
    btn = 7'h02;
    cyc(6);
    check("repress_sus", sus7, 0);
    check("repress_freq", freq7, 587);
    cyc(10);
    check("repress_hold", valid7, 1);
    check("repress_hold_freq", freq7, 587);

    // Reset in the middle of sustain.
    btn = '0;
    cyc(8);
    check("mid_sus", sus7, 1);
    rst = 1'b1;
    cyc(1);
    check("rst_sus_freq", freq7, 1);
    check("rst_sus", sus7, 0);
    rst = 1'b0;
    cyc(5);

    // Randomised phase, checked only through the scoreboard.
    cycles = 0;
    while (cycles < 3000) begin
      case ($urandom_range(0, 3))
        0:       btn = '0;
        1:       btn = 7'($urandom);
        default: btn = 7'($urandom) & 7'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) sw = 3'($urandom);
      rst  = ($urandom_range(0, 59) == 0);
      hold = (btn == '0) ? $urandom_range(1, 16) : $urandom_range(1, 10);
      cyc(hold);
      cycles += hold;
    end
    rst = 1'b0;
    btn = '0;
    cyc(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
